// File: rtl/operand_fwd_sb.sv
// Decode-to-EX operand stage: resolves source operands through a priority
// forward network, tracks long-latency destinations in a busy scoreboard.
module operand_fwd_sb #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int NFWD = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dec_valid_i,
  output logic               dec_ready_o,
  input  logic [AW-1:0]      rs_addr_i,
  input  logic [AW-1:0]      rt_addr_i,
  input  logic               rs_read_i,
  input  logic               rt_read_i,
  input  logic [DW-1:0]      imm_i,
  input  logic [AW-1:0]      wd_i,
  input  logic               wreg_i,
  input  logic               long_i,
  input  logic [DW-1:0]      rf_rs_data_i,
  input  logic [DW-1:0]      rf_rt_data_i,
  input  logic [NFWD-1:0]    fwd_valid_i,
  input  logic [NFWD-1:0]    fwd_pend_i,
  input  logic [NFWD*AW-1:0] fwd_addr_i,
  input  logic [NFWD*DW-1:0] fwd_data_i,
  input  logic               lw_done_i,
  input  logic [AW-1:0]      lw_addr_i,
  input  logic               flush_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [DW-1:0]      reg1_o,
  output logic [DW-1:0]      reg2_o,
  output logic [AW-1:0]      wd_o,
  output logic               wreg_o,
  output logic               stall_req_o,
  output logic [15:0]        stall_cnt_o
);

  localparam int NREG = 2 ** AW;

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  logic [AW-1:0] src_addr [2];
  logic          src_rd   [2];
  logic [DW-1:0] src_rf   [2];
  logic [DW-1:0] src_val  [2];
  logic [1:0]    src_haz;
  logic          waw_haz;
  logic          hazard;
  logic          accept;
  logic          sb_set;

  assign src_addr[0] = rs_addr_i;
  assign src_addr[1] = rt_addr_i;
  assign src_rd[0]   = rs_read_i;
  assign src_rd[1]   = rt_read_i;
  assign src_rf[0]   = rf_rs_data_i;
  assign src_rf[1]   = rf_rt_data_i;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      src_val[s] = src_rf[s];
      src_haz[s] = 1'b0;
      if (!src_rd[s]) begin
        src_val[s] = imm_i;
      end else if (src_addr[s] == '0) begin
        src_val[s] = '0;
      end else begin
        // Walk oldest to youngest so the lowest-index match is applied last.
        for (int k = NFWD - 1; k >= 0; k--) begin
          if (fwd_valid_i[k] && fwd_addr_i[k*AW +: AW] == src_addr[s]) begin
            src_val[s] = fwd_data_i[k*DW +: DW];
            src_haz[s] = fwd_pend_i[k];
          end
        end
        src_haz[s] = src_haz[s] | busy[src_addr[s]];
      end
    end
  end

  assign waw_haz     = wreg_i && (wd_i != '0) && busy[wd_i];
  assign hazard      = |src_haz || waw_haz;
  assign stall_req_o = dec_valid_i && hazard;
  assign dec_ready_o = !hazard && (!out_valid_o || out_ready_i) && !flush_i;
  assign accept      = dec_valid_i && dec_ready_o;
  assign sb_set      = accept && long_i && wreg_i && (wd_i != '0);

  // Set is applied after clear so a same-cycle set of the same bit wins.
  always_comb begin
    busy_nxt = busy;
    if (lw_done_i) busy_nxt[lw_addr_i] = 1'b0;
    if (sb_set)    busy_nxt[wd_i]      = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // NOTE: the scoreboard is a bank of flops, not a RAM, so it can and must be
  // cleared by reset; a reset left in flight would otherwise stall forever.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= '0;
    else      busy <= busy_nxt;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_o <= 1'b0;
      reg1_o      <= '0;
      reg2_o      <= '0;
      wd_o        <= '0;
      wreg_o      <= 1'b0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
    end else if (accept) begin
      out_valid_o <= 1'b1;
      reg1_o      <= src_val[0];
      reg2_o      <= src_val[1];
      wd_o        <= wd_i;
      // Long results return through lw_done, not through the forward path.
      wreg_o      <= wreg_i && !long_i;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                      stall_cnt_o <= '0;
    else if (stall_req_o && stall_cnt_o != 16'hFFFF) stall_cnt_o <= stall_cnt_o + 16'd1;
  end

endmodule

// File: tb/tb_operand_fwd_sb.sv
// Bench for operand_fwd_sb: directed scenarios plus random traffic, all
// compared against a rule-level reference model of the operand stage.
module tb_operand_fwd_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NF = 2;

  logic clk = 1'b0;
  logic rst;
  logic dec_valid, dec_ready, rs_read, rt_read, wreg, long_op;
  logic [AW-1:0] rs_addr, rt_addr, wd, lw_addr;
  logic [DW-1:0] imm, rf_rs, rf_rt;
  logic [NF-1:0] fwd_valid, fwd_pend;
  logic [NF*AW-1:0] fwd_addr;
  logic [NF*DW-1:0] fwd_data;
  logic lw_done, flush, out_valid, out_ready, wreg_o, stall_req;
  logic [DW-1:0] reg1, reg2;
  logic [AW-1:0] wd_o;
  logic [15:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  bit          m_busy [32];
  bit          m_ov;
  logic [31:0] m_r1, m_r2;
  logic [4:0]  m_wd;
  bit          m_wreg;
  int          m_cnt;

  always #5 clk = ~clk;

  operand_fwd_sb #(.DW(DW), .AW(AW), .NFWD(NF)) dut (
    .clk(clk), .rst(rst),
    .dec_valid_i(dec_valid), .dec_ready_o(dec_ready),
    .rs_addr_i(rs_addr), .rt_addr_i(rt_addr),
    .rs_read_i(rs_read), .rt_read_i(rt_read),
    .imm_i(imm), .wd_i(wd), .wreg_i(wreg), .long_i(long_op),
    .rf_rs_data_i(rf_rs), .rf_rt_data_i(rf_rt),
    .fwd_valid_i(fwd_valid), .fwd_pend_i(fwd_pend),
    .fwd_addr_i(fwd_addr), .fwd_data_i(fwd_data),
    .lw_done_i(lw_done), .lw_addr_i(lw_addr), .flush_i(flush),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .reg1_o(reg1), .reg2_o(reg2), .wd_o(wd_o), .wreg_o(wreg_o),
    .stall_req_o(stall_req), .stall_cnt_o(stall_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    m_ov = 0; m_r1 = '0; m_r2 = '0; m_wd = '0; m_wreg = 0; m_cnt = 0;
  endtask

  task automatic idle();
    dec_valid = 0; rs_addr = '0; rt_addr = '0; rs_read = 0; rt_read = 0;
    imm = '0; wd = '0; wreg = 0; long_op = 0; rf_rs = '0; rf_rt = '0;
    fwd_valid = '0; fwd_pend = '0; fwd_addr = '0; fwd_data = '0;
    lw_done = 0; lw_addr = '0; flush = 0; out_ready = 1;
  endtask

  // Operand value as seen by the instruction, plus whether it must wait.
  function automatic logic [31:0] opnd(input logic [4:0] a, input logic rd,
                                       input logic [31:0] rf, output bit hz);
    hz = 0;
    if (!rd) return imm;
    if (a == 0) return 32'h0;
    hz = m_busy[a];
    for (int k = 0; k < NF; k++) begin
      if (fwd_valid[k] && fwd_addr[k*AW +: AW] == a) begin
        hz = hz | fwd_pend[k];
        return fwd_data[k*DW +: DW];
      end
    end
    return rf;
  endfunction

  // One clock: check handshake outputs mid-cycle, advance model, check regs.
  task automatic step();
    logic [31:0] e1, e2;
    bit h1, h2, hz, e_ready, acc;
    #1;
    e1 = opnd(rs_addr, rs_read, rf_rs, h1);
    e2 = opnd(rt_addr, rt_read, rf_rt, h2);
    hz = h1 || h2 || (wreg && wd != 0 && m_busy[wd]);
    e_ready = !hz && (!m_ov || out_ready) && !flush;
    acc = dec_valid && e_ready;
    check("dec_ready", dec_ready, e_ready);
    check("stall_req", stall_req, dec_valid && hz);
    @(posedge clk);
    if (dec_valid && hz && m_cnt < 65535) m_cnt++;
    if (lw_done) m_busy[lw_addr] = 0;
    if (acc && long_op && wreg && wd != 0) m_busy[wd] = 1;
    if (flush) m_ov = 0;
    else if (acc) begin
      m_ov = 1; m_r1 = e1; m_r2 = e2; m_wd = wd; m_wreg = wreg && !long_op;
    end else if (out_ready) m_ov = 0;
    #1;
    check("out_valid", out_valid, m_ov);
    check("reg1", reg1, m_r1);
    check("reg2", reg2, m_r2);
    check("wd_o", wd_o, m_wd);
    check("wreg_o", wreg_o, m_wreg);
    check("stall_cnt", stall_cnt, m_cnt);
  endtask

  initial begin
    idle();
    model_reset();
    rst = 0;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_reg1", reg1, 0);
    check("rst_cnt", stall_cnt, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1;

    // load-use pending forward stalls one cycle, then proceeds
    dec_valid = 1; rs_read = 1; rs_addr = 5;
    fwd_valid = 2'b01; fwd_pend = 2'b01; fwd_addr = {5'd0, 5'd5}; fwd_data = {32'h0, 32'hC0DE};
    #1;
    check("pend_stall", stall_req, 1);
    check("pend_ready", dec_ready, 0);
    step();
    check("pend_cnt", stall_cnt, 1);
    fwd_pend = '0;
    step();
    check("pend_acc_valid", out_valid, 1);
    check("pend_acc_reg1", reg1, 32'hC0DE);

    // youngest forward source wins
    idle(); dec_valid = 1; rs_read = 1; rs_addr = 3; rf_rs = 32'h9999;
    fwd_valid = 2'b11; fwd_addr = {5'd3, 5'd3}; fwd_data = {32'hBBBB, 32'hAAAA};
    step();
    check("prio_reg1", reg1, 32'hAAAA);

    // r0 reads zero, unread operand takes the immediate
    idle(); dec_valid = 1; rs_read = 1; rs_addr = 0; rt_read = 0; rt_addr = 4; imm = 32'h00FF;
    fwd_valid = 2'b01; fwd_addr = {5'd0, 5'd0}; fwd_data = {32'h0, 32'h1234};
    step();
    check("r0_reg1", reg1, 0);
    check("imm_reg2", reg2, 32'h00FF);

    // long op to r7 then a reader stalls until the cycle after lw_done
    idle(); dec_valid = 1; wd = 7; wreg = 1; long_op = 1;
    step();
    check("long_wreg_o", wreg_o, 0);
    idle(); dec_valid = 1; rs_read = 1; rs_addr = 7;
    #1;
    check("busy_stall", stall_req, 1);
    step(); step();
    lw_done = 1; lw_addr = 7;
    #1;
    check("lw_cycle_ready", dec_ready, 0);
    step();
    lw_done = 0;
    #1;
    check("lw_next_ready", dec_ready, 1);
    step();
    check("lw_acc_valid", out_valid, 1);

    // backpressure holds outputs, flush drops them and keeps busy bits
    idle(); dec_valid = 1; wd = 7; wreg = 1; long_op = 1;
    step();
    idle(); dec_valid = 1; imm = 32'h55; wd = 3; wreg = 1;
    step();
    out_ready = 0; imm = 32'h66; wd = 4;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready", dec_ready, 0);
      step();
      check("bp_reg1", reg1, 32'h55);
      check("bp_valid", out_valid, 1);
    end
    flush = 1; dec_valid = 1;
    #1;
    check("flush_ready", dec_ready, 0);
    step();
    check("flush_valid", out_valid, 0);
    idle(); dec_valid = 1; rs_read = 1; rs_addr = 7;
    #1;
    check("flush_busy_kept", stall_req, 1);

    // asynchronous reset while stalled on busy r7
    rst = 0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_reg1", reg1, 0);
    check("arst_reg2", reg2, 0);
    check("arst_wd", wd_o, 0);
    check("arst_cnt", stall_cnt, 0);
    check("arst_stall", stall_req, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1;
    step();
    check("post_rst_acc", out_valid, 1);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      dec_valid = ($urandom % 4) != 0;
      rs_addr = 5'($urandom % 8);   rt_addr = 5'($urandom % 8);
      rs_read = 1'($urandom);       rt_read = 1'($urandom);
      imm = $urandom;               rf_rs = $urandom;   rf_rt = $urandom;
      wd = 5'($urandom % 8);        wreg = 1'($urandom);
      long_op = ($urandom % 5) == 0;
      fwd_valid = 2'($urandom);
      fwd_pend = {($urandom % 4) == 0, ($urandom % 4) == 0};
      fwd_addr = {5'($urandom % 8), 5'($urandom % 8)};
      fwd_data = {$urandom, $urandom};
      lw_done = ($urandom % 3) == 0;  lw_addr = 5'($urandom % 8);
      flush = ($urandom % 16) == 0;   out_ready = ($urandom % 4) != 0;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
